fetch_queue: RTL and testbench



---
 rtl/fetch_queue_pkg.sv | 12 +
 rtl/fetch_queue_fifo.sv | 40 ++++
 rtl/fetch_queue.sv | 85 ++++++++
 tb/tb_fetch_queue.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared defaults and queue entry layout for the fetch queue.
package fetch_queue_pkg;
  localparam int          WORD_WIDTH_DEF = 32;
  localparam int          ADDR_WIDTH_DEF = 9;
  localparam int          DEPTH_DEF      = 4;
  localparam logic [31:0] BOOT_ADDR_DEF  = 32'h0000_0000;

  // An entry is {pc, ir}: pc in the high half, instruction in the low half.
  function automatic int entry_width(input int word_width);
    return 2 * word_width;
  endfunction
endpackage

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO of fetched entries; clear wins over push/pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;

  // Storage array: no reset, contents only matter while counted valid.
  always_ff @(posedge clk) begin
    if (push && !clear && !rst) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout = mem[rd_ptr];
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch with credit-based issue into a DEPTH-entry {pc, ir} queue.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                    WORD_WIDTH = WORD_WIDTH_DEF,
  parameter logic [WORD_WIDTH-1:0] BOOT_ADDR  = BOOT_ADDR_DEF,
  parameter int                    DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump,
  input  logic [WORD_WIDTH-1:0] target,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_pc,
  output logic [WORD_WIDTH-1:0] out_ir
);
  localparam int EW = entry_width(WORD_WIDTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WORD_WIDTH-1:0] fetch_pc, inflight_pc;
  logic                  inflight;
  logic [CW-1:0]         count;
  logic [EW-1:0]         head;
  logic                  pop, push, space;
  logic [CW:0]           occupancy;

  assign out_valid = (count != '0) & ~jump & ~rst;
  assign pop       = out_valid & out_ready;
  assign push      = inflight & ~jump & ~rst;

  // Credits: entries held plus the read in flight, minus what leaves now.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign space     = occupancy < (CW+1)'(DEPTH);

  // Memory strobe/address: reset parks at boot, redirect issues the target.
  always_comb begin
    mem_en   = 1'b0;
    mem_addr = fetch_pc[ADDR_WIDTH-1:0];
    if (rst) begin
      mem_addr = BOOT_ADDR[ADDR_WIDTH-1:0];
    end else if (jump) begin
      mem_en   = 1'b1;
      mem_addr = target[ADDR_WIDTH-1:0];
    end else if (space) begin
      mem_en   = 1'b1;
    end
  end

  // Issue state: rst > jump > normal issue; no credit means the pc holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= BOOT_ADDR;
      inflight <= 1'b0;
    end else if (jump) begin
      fetch_pc    <= target + WORD_WIDTH'(1);
      inflight    <= 1'b1;
      inflight_pc <= target;
    end else if (space) begin
      fetch_pc    <= fetch_pc + WORD_WIDTH'(1);
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (jump),
    .push  (push),
    .din   ({inflight_pc, mem_data}),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  assign out_pc = head[EW-1 -: WORD_WIDTH];
  assign out_ir = head[WORD_WIDTH-1:0];
endmodule

// File: tb/tb_fetch_queue.sv
// Directed + random bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk, rst, jump, out_ready, mem_en, out_valid;
  logic [31:0] target, mem_data, out_pc, out_ir;
  logic [8:0]  mem_addr;

  int checks   = 0;
  int failures = 0;

  // Reference state: queued pcs, read in flight, next pc to fetch.
  logic [31:0] m_q[$];
  logic        m_infl = 1'b0;
  logic [31:0] m_infl_pc = '0;
  logic [31:0] m_fpc = '0;

  // Values observed in the most recent step.
  logic        s_valid, s_en;
  logic [31:0] s_pc, s_ir;
  logic [8:0]  s_addr;

  fetch_queue dut (
    .clk(clk), .rst(rst), .jump(jump), .target(target),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ir(out_ir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ram(input logic [8:0] a);
    return {23'd0, a} + 32'h100;
  endfunction

  // Synchronous instruction memory, one-cycle read latency.
  always @(posedge clk) if (mem_en) mem_data <= ram(mem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic j, input logic [31:0] t, input logic rdy);
    logic e_valid, e_pop, e_space, e_en;
    logic [8:0] e_addr;
    rst = r; jump = j; target = t; out_ready = rdy;
    @(negedge clk);
    e_valid = !r && !j && (m_q.size() != 0);
    e_pop   = e_valid && rdy;
    e_space = (m_q.size() + int'(m_infl) - int'(e_pop)) < DEPTH;
    e_en    = !r && (j || e_space);
    e_addr  = r ? 9'd0 : (j ? t[8:0] : m_fpc[8:0]);
    s_valid = out_valid; s_en = mem_en; s_addr = mem_addr; s_pc = out_pc; s_ir = out_ir;
    chk("out_valid", 64'(s_valid), 64'(e_valid));
    chk("mem_en", 64'(s_en), 64'(e_en));
    if (e_en || r) chk("mem_addr", 64'(s_addr), 64'(e_addr));
    if (e_valid) begin
      chk("out_pc", 64'(s_pc), 64'(m_q[0]));
      chk("out_ir", 64'(s_ir), 64'(ram(m_q[0][8:0])));
    end
    @(posedge clk);
    if (r) begin
      m_q.delete(); m_infl = 1'b0; m_fpc = 32'h0;
    end else if (j) begin
      m_q.delete(); m_infl = 1'b1; m_infl_pc = t; m_fpc = t + 32'd1;
    end else begin
      if (e_pop) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_infl_pc);
      if (e_space) begin
        m_infl = 1'b1; m_infl_pc = m_fpc; m_fpc = m_fpc + 32'd1;
      end else m_infl = 1'b0;
    end
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; jump = 1'b0; target = '0; out_ready = 1'b1;
    // Reset, then release with decode always ready.
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1); chk("rel_lat0", 64'(s_valid), 64'd0);
    step(0, 0, 0, 1); chk("rel_lat1", 64'(s_valid), 64'd0);
    step(0, 0, 0, 1); chk("first_pc", 64'(s_pc), 64'h0);
    chk("first_ir", 64'(s_ir), 64'h100);
    step(0, 0, 0, 1); chk("second_pc", 64'(s_pc), 64'h1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

    // Decode stall: queue fills to DEPTH and issue stops.
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    chk("stall_mem_en", 64'(s_en), 64'd0);
    chk("stall_depth", 64'(m_q.size()), 64'(DEPTH));
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);

    // Redirect while 3 entries are queued.
    n = 0;
    while (m_q.size() != 3 && n < 20) begin step(0, 0, 0, 0); n++; end
    chk("fill3", 64'(m_q.size()), 64'd3);
    step(0, 1, 32'h40, 1);
    chk("jmp_valid", 64'(s_valid), 64'd0);
    chk("jmp_addr", 64'(s_addr), 64'h40);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1); chk("jmp_pc", 64'(s_pc), 64'h40);
    step(0, 0, 0, 1); chk("jmp_pc1", 64'(s_pc), 64'h41);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // Back-to-back redirects: only the second target is delivered.
    step(0, 1, 32'h10, 1);
    step(0, 1, 32'h20, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1); chk("b2b_pc", 64'(s_pc), 64'h20);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // Reset mid-stream with entries queued.
    n = 0;
    while (m_q.size() != 2 && n < 20) begin step(0, 0, 0, 0); n++; end
    step(1, 0, 0, 1); chk("rst_en", 64'(s_en), 64'd0);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1); chk("rst_restart_pc", 64'(s_pc), 64'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // Address wrap at the top of the pc space.
    step(0, 1, 32'hFFFF_FFFF, 1); chk("wrap_addr0", 64'(s_addr), 64'h1FF);
    step(0, 0, 0, 1); chk("wrap_addr1", 64'(s_addr), 64'h000);
    step(0, 0, 0, 1); chk("wrap_pc0", 64'(s_pc), 64'hFFFF_FFFF);
    step(0, 0, 0, 1); chk("wrap_pc1", 64'(s_pc), 64'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic r, j, rdy;
      logic [31:0] t;
      r   = ($urandom_range(0, 49) == 0);
      j   = !r && ($urandom_range(0, 9) == 0);
      t   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFD + $urandom_range(0, 3)) : $urandom();
      rdy = ($urandom_range(0, 3) != 0);
      step(r, j, t, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
